exec_unit: RTL and testbench

//   Execute stage directly downstream of the register file. Latches operands read on
//   dat1/dat2, runs one ALU op (1 cycle) or a MUL/DIV sequence (16 iterations), then

---
 rtl/exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_exec_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus 16-step shift-add multiply and restoring divide.
// Results come back on w1/w15 with a register-file write select on dst during the one-cycle done pulse.
module exec_unit #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] dat1,
  input  logic [WIDTH-1:0] dat2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w15,
  output logic [1:0]       dst,
  output logic             carry,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_MUL = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV = OPW'(5);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] w1_q, w1_d;
  logic [WIDTH-1:0] w15_q, w15_d;
  logic [1:0]       dst_q, dst_d;
  logic             carry_q, carry_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   add_res, sub_res, mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration: hi:lo is the product accumulator (MUL) or remainder:dividend-shifter (DIV); a_q holds the other operand.
  always_comb begin
    add_res   = {1'b0, dat1} + {1'b0, dat2};
    sub_res   = {1'b0, dat1} - {1'b0, dat2};
    mul_sum   = {1'b0, hi_q} + {1'b0, a_q};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, a_q};
    step_hi   = hi_q;
    step_lo   = lo_q;
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end else begin
      {step_hi, step_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    w1_d     = w1_q;
    w15_d    = w15_q;
    dst_d    = 2'b00;
    carry_d  = carry_q;
    div0_d   = div0_q;
    case (state_q)
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          w1_d    = step_lo;
          w15_d   = step_hi;
          dst_d   = 2'b11;
          carry_d = 1'b0;
          div0_d  = 1'b0;
        end
      end
      default: begin
        // DONE behaves like IDLE for acceptance so back-to-back requests are taken.
        state_d = IDLE;
        if (start) begin
          state_d = DONE;
          w15_d   = '0;
          carry_d = 1'b0;
          div0_d  = 1'b0;
          case (op)
            OP_ADD: begin
              {carry_d, w1_d} = add_res;
              dst_d           = 2'b01;
            end
            OP_SUB: begin
              {carry_d, w1_d} = sub_res;
              dst_d           = 2'b01;
            end
            OP_AND: begin
              w1_d  = dat1 & dat2;
              dst_d = 2'b01;
            end
            OP_OR: begin
              w1_d  = dat1 | dat2;
              dst_d = 2'b01;
            end
            OP_MUL, OP_DIV: begin
              if (op == OP_DIV && dat2 == '0) begin
                w1_d   = '1;
                w15_d  = dat1;
                div0_d = 1'b1;
              end else begin
                state_d  = RUN;
                is_div_d = (op == OP_DIV);
                a_d      = (op == OP_DIV) ? dat2 : dat1;
                lo_d     = (op == OP_DIV) ? dat1 : dat2;
                hi_d     = '0;
                cnt_d    = '0;
                w1_d     = w1_q;
                w15_d    = w15_q;
                carry_d  = carry_q;
                div0_d   = div0_q;
              end
            end
            default: w1_d = '0;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      w1_q     <= '0;
      w15_q    <= '0;
      dst_q    <= 2'b00;
      carry_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      w1_q     <= w1_d;
      w15_q    <= w15_d;
      dst_q    <= dst_d;
      carry_q  <= carry_d;
      div0_q   <= div0_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign w1    = w1_q;
  assign w15   = w15_q;
  assign dst   = dst_q;
  assign carry = carry_q;
  assign div0  = div0_q;

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed corner cases and random traffic, checked by a
// queue-based scoreboard fed from an arithmetic reference model.
module tb_exec_unit;

   logic        CLOCK;
   logic        CLEAR;
   logic        start;
   logic [2:0]  opIn;
   logic [15:0] dat1;
   logic [15:0] dat2;
   logic        busy;
   logic        done;
   logic [15:0] w1;
   logic [15:0] w15;
   logic [1:0]  dst;
   logic        carry;
   logic        div0;

   typedef struct {
      logic [15:0] w1;
      logic [15:0] w15;
      logic [1:0]  dst;
      logic        carry;
      logic        div0;
      int          due;
   } exp_t;

   exp_t expQ[$];
   int   cyc = 0;
   int   assertCount = 0;
   int   failCount = 0;
   int   issued = 0;
   int   doneCount = 0;
   bit   monitorOn = 0;

   exec_unit #(.WIDTH(16), .OPW(3)) dut (
      .CLOCK(CLOCK),
      .CLEAR(CLEAR),
      .start(start),
      .op(opIn),
      .dat1(dat1),
      .dat2(dat2),
      .busy(busy),
      .done(done),
      .w1(w1),
      .w15(w15),
      .dst(dst),
      .carry(carry),
      .div0(div0)
   );

   // Free-running clock with a cycle counter so expected done times can be stated as absolute cycles
   initial begin
      CLOCK = 0;
      forever #5 CLOCK = ~CLOCK;
   end

   always @(posedge CLOCK) cyc <= cyc + 1;

   // Single comparison point: every check in the bench funnels through here so counts stay honest
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: the architectural result of each opcode using plain integer arithmetic
   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      int unsigned prod;
      logic [16:0] sum;
      e.w1 = 16'h0; e.w15 = 16'h0; e.dst = 2'b00; e.carry = 1'b0; e.div0 = 1'b0; e.due = 0;
      case (op)
         3'd0: begin sum = {1'b0, a} + {1'b0, b}; e.w1 = sum[15:0]; e.carry = sum[16]; e.dst = 2'b01; end
         3'd1: begin e.w1 = a - b; e.carry = (a < b); e.dst = 2'b01; end
         3'd2: begin e.w1 = a & b; e.dst = 2'b01; end
         3'd3: begin e.w1 = a | b; e.dst = 2'b01; end
         3'd4: begin
            prod = int'(a) * int'(b);
            e.w1 = prod[15:0]; e.w15 = prod[31:16]; e.dst = 2'b11;
         end
         3'd5: begin
            if (b == 16'h0) begin
               e.w1 = 16'hFFFF; e.w15 = a; e.div0 = 1'b1;
            end else begin
               e.w1 = a / b; e.w15 = a % b; e.dst = 2'b11;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic bit isLong(input logic [2:0] op, input logic [15:0] b);
      return (op == 3'd4) || (op == 3'd5 && b != 16'h0);
   endfunction

   // Waits (bounded) until the unit can accept, issues one request and records what should come back
   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   guard = 0;
      while (busy && guard < 40) begin
         @(negedge CLOCK);
         guard++;
      end
      checkOutput("acceptWaitBusy", {31'b0, busy}, 32'd0);
      opIn  = op;
      dat1  = a;
      dat2  = b;
      start = 1'b1;
      @(posedge CLOCK);
      #1;
      e     = model(op, a, b);
      e.due = cyc + (isLong(op, b) ? 16 : 0);
      expQ.push_back(e);
      issued++;
      @(negedge CLOCK);
      start = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever done is seen and flags late, missing or unexpected results
   always @(negedge CLOCK) begin
      exp_t e;
      if (monitorOn) begin
         if (done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedDone: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
               e = expQ.pop_front();
               checkOutput("doneCycle", cyc, e.due);
               checkOutput("w1", {16'b0, w1}, {16'b0, e.w1});
               checkOutput("w15", {16'b0, w15}, {16'b0, e.w15});
               checkOutput("dst", {30'b0, dst}, {30'b0, e.dst});
               checkOutput("carry", {31'b0, carry}, {31'b0, e.carry});
               checkOutput("div0", {31'b0, div0}, {31'b0, e.div0});
            end
         end else begin
            checkOutput("dstIdle", {30'b0, dst}, 32'd0);
            if (expQ.size() > 0 && expQ[0].due < cyc) begin
               e = expQ.pop_front();
               assertCount++;
               failCount++;
               $display("[TB] FAIL missingDone: got no done by cycle %0d expected done at %0d", cyc, e.due);
            end
         end
      end
   end

   // Main sequence: reset, directed corner cases, abort, back-to-back, then random traffic
   initial begin
      logic [2:0]  rOp;
      logic [15:0] rA;
      logic [15:0] rB;
      int          guard;

      CLEAR = 1'b0;
      start = 1'b1;
      opIn  = 3'd4;
      dat1  = 16'h1234;
      dat2  = 16'h5678;
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      checkOutput("resetBusy", {31'b0, busy}, 32'd0);
      checkOutput("resetDone", {31'b0, done}, 32'd0);
      checkOutput("resetDst", {30'b0, dst}, 32'd0);
      checkOutput("resetW1", {16'b0, w1}, 32'd0);
      checkOutput("resetW15", {16'b0, w15}, 32'd0);
      checkOutput("resetCarry", {31'b0, carry}, 32'd0);
      checkOutput("resetDiv0", {31'b0, div0}, 32'd0);
      start     = 1'b0;
      CLEAR     = 1'b1;
      monitorOn = 1;
      @(negedge CLOCK);

      applyStimulus(3'd0, 16'hFFFF, 16'h0001);
      applyStimulus(3'd1, 16'h0003, 16'h0005);

      applyStimulus(3'd4, 16'h1234, 16'h00FF);
      for (int i = 0; i < 16; i++) begin
         checkOutput("mulBusy", {31'b0, busy}, 32'd1);
         start = i[0];
         opIn  = 3'($urandom_range(0, 7));
         dat1  = 16'($urandom);
         dat2  = 16'($urandom);
         @(negedge CLOCK);
      end
      checkOutput("mulBusyInDone", {31'b0, busy}, 32'd0);
      applyStimulus(3'd2, 16'hF0F0, 16'h0FF0);

      applyStimulus(3'd5, 16'd1000, 16'd7);
      applyStimulus(3'd5, 16'h0005, 16'h0000);
      applyStimulus(3'd6, 16'hABCD, 16'h1111);
      applyStimulus(3'd7, 16'h0001, 16'h0002);

      applyStimulus(3'd4, 16'hBEEF, 16'hCAFE);
      repeat (7) @(negedge CLOCK);
      CLEAR = 1'b0;
      expQ.delete();
      issued--;
      @(negedge CLOCK);
      CLEAR = 1'b1;
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortW1", {16'b0, w1}, 32'd0);
      applyStimulus(3'd0, 16'd2, 16'd3);

      for (int n = 0; n < 60; n++) begin
         rOp = 3'($urandom_range(0, 7));
         rA  = 16'($urandom);
         case ($urandom_range(0, 3))
            0: rB = 16'h0;
            1: rB = 16'($urandom_range(1, 20));
            default: rB = 16'($urandom);
         endcase
         applyStimulus(rOp, rA, rB);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLOCK);
      end

      guard = 0;
      while (expQ.size() > 0 && guard < 60) begin
         @(negedge CLOCK);
         guard++;
      end
      checkOutput("drainQueue", expQ.size(), 32'd0);
      checkOutput("doneTotal", doneCount, issued);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
